uart_tx_arbiter: RTL and testbench

- Round-robin packet arbiter that shares one uart transmit path (its wr_uart / w_data / tx_full write port) between N_REQ requesters.
- A requester sends a packet as a byte stream with a last-byte flag.
- Once granted, a requester keeps the grant until its last byte is accepted, or until an inactivity timeout aborts it. This keeps packets from different requesters from interleaving in the TX FIFO.
- Sits between the software/peripheral byte sources and the uart block.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart TX write port.
// A requester that wins keeps the port until its last byte is accepted or
// until it goes quiet for TIMEOUT cycles mid-packet, so packets never
// interleave in the uart FIFO.

// Per-lane gating: only the granted lane sees ready and drives the shared bus.
module uart_tx_arb_lane (
  input  logic       sel,
  input  logic       valid,
  input  logic       last,
  input  logic [7:0] data,
  input  logic       tx_full,
  output logic       ready,
  output logic       valid_m,
  output logic       last_m,
  output logic [7:0] data_m
);
  // A lane only sees ready while it owns the port and the FIFO has room
  always_comb begin
    ready   = sel & ~tx_full;
    valid_m = sel & valid;
    last_m  = sel & last;
    data_m  = sel ? data : 8'h00;
  end
endmodule

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 abort,
  output logic [15:0]          pkt_count,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [7:0]           w_data
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                     state;
  logic [IW-1:0]              owner;
  logic [IW-1:0]              last_owner;
  logic [TW-1:0]              timer;

  logic [N_REQ-1:0]           valid_v;
  logic [N_REQ-1:0]           last_v;
  logic [N_REQ-1:0][7:0]      data_m;
  logic                       own_valid;
  logic                       own_last;
  logic                       xfer;
  logic                       pick_found;
  logic [IW-1:0]              pick_idx;

  // grant is zero in IDLE, so every lane is masked off there
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    uart_tx_arb_lane u_lane (
      .sel     (grant[g]),
      .valid   (req_valid[g]),
      .last    (req_last[g]),
      .data    (req_data[8*g +: 8]),
      .tx_full (tx_full),
      .ready   (req_ready[g]),
      .valid_m (valid_v[g]),
      .last_m  (last_v[g]),
      .data_m  (data_m[g])
    );
  end

  // Collapse the masked lanes onto the single uart write port
  always_comb begin
    w_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) w_data = w_data | data_m[i];
    own_valid = |valid_v;
    own_last  = |last_v;
    xfer      = |(req_valid & req_ready);
    wr_uart   = xfer;
    busy      = (state == OWN);
  end

  // Rotating search starting just after the previous owner
  always_comb begin
    int c;
    c          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(last_owner) + k) % N_REQ;
      if (!pick_found && req_valid[c]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(c);
      end
    end
  end

  // Ownership FSM: arbitrate in IDLE, hold the grant through the packet in OWN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= IW'(N_REQ - 1);
      timer      <= '0;
      abort      <= 1'b0;
      pkt_count  <= 16'h0000;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= OWN;
            owner <= pick_idx;
            grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            timer <= '0;
          end
        end
        OWN: begin
          if (xfer) begin
            timer <= '0;
            if (own_last) begin
              state      <= IDLE;
              grant      <= '0;
              last_owner <= owner;
              pkt_count  <= pkt_count + 16'd1;
            end
          end else if (own_valid) begin
            // back-pressure stall: owner is still there, never time out
            timer <= '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= owner;
            timer      <= '0;
            abort      <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=10).
module tb_uart_tx_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        abort;
  logic [15:0] pkt_count;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;

  int n_chk = 0;
  int n_err = 0;

  // per-lane source queues of {last, data}
  logic [8:0] q [4][$];
  // bytes seen on the uart port and which lane owned it
  logic [7:0] log_d[$];
  logic [1:0] log_s[$];
  logic [7:0] exp_d[$];
  logic [1:0] exp_s[$];

  // negedge snapshot of the last cycle
  logic [3:0]  s_grant, s_ready, s_valid;
  logic        s_busy, s_abort, s_wr;
  logic [7:0]  s_wd;
  logic [15:0] s_cnt;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .abort     (abort),
    .pkt_count (pkt_count),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = q[i][0][7:0];
        req_last[i]        = q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic push(input int lane, input logic last, input logic [7:0] d);
    q[lane].push_back({last, d});
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) q[i].delete();
    log_d.delete();
    log_s.delete();
  endtask

  // One clock: snapshot at negedge, then retire accepted bytes after the edge
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    s_grant = grant; s_ready = req_ready; s_valid = req_valid;
    s_busy = busy; s_abort = abort; s_wr = wr_uart; s_wd = w_data; s_cnt = pkt_count;
    acc = req_valid & req_ready;
    if (wr_uart) begin
      log_d.push_back(w_data);
      log_s.push_back(enc(grant));
    end
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("no_wr_when_full", 32'(wr_uart & tx_full), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int max);
    logic done;
    done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      tick();
      if (!s_busy && q[0].size() == 0 && q[1].size() == 0 &&
          q[2].size() == 0 && q[3].size() == 0) done = 1'b1;
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(log_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < log_d.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 32'(log_d[i]), 32'(exp_d[i]));
        chk($sformatf("%s_src%0d", tag, i), 32'(log_s[i]), 32'(exp_s[i]));
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tx_full = 1'b0;
    clear_all();
    drive();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int first_ab, n_ab;
    logic st_wr, st_rdy, st_ab, st_busy;
    logic [3:0]  gr [1:20];
    logic [15:0] cn [1:20];

    reset = 1'b0;
    tx_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    clear_all();
    // req0 is already valid during reset: nothing may be accepted
    push(0, 1'b0, 8'h55);
    push(0, 1'b1, 8'hAA);
    drive();
    #1;
    tick();
    tick();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_abort", 32'(s_abort), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    chk("rst_wr", 32'(s_wr), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_wdata", 32'(s_wd), 32'd0);
    reset = 1'b1;

    // 1: single packet from req0
    tick();
    chk("t1_idle_grant", 32'(s_grant), 32'd0);
    chk("t1_idle_wr", 32'(s_wr), 32'd0);
    chk("t1_idle_wdata", 32'(s_wd), 32'd0);
    tick();
    chk("t1_grant", 32'(s_grant), 32'b0001);
    chk("t1_wr0", 32'(s_wr), 32'd1);
    chk("t1_byte0", 32'(s_wd), 32'h55);
    tick();
    chk("t1_wr1", 32'(s_wr), 32'd1);
    chk("t1_byte1", 32'(s_wd), 32'hAA);
    tick();
    chk("t1_release", 32'(s_grant), 32'd0);
    chk("t1_busy", 32'(s_busy), 32'd0);
    chk("t1_cnt", 32'(s_cnt), 32'd1);

    // 2: round robin among req0..2, req0 has a second packet
    apply_reset();
    push(0, 1'b1, 8'h10);
    push(0, 1'b1, 8'h11);
    push(1, 1'b1, 8'h21);
    push(2, 1'b1, 8'h32);
    drive();
    run_until_idle("t2", 40);
    exp_d = '{8'h10, 8'h21, 8'h32, 8'h11};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};
    check_log("t2");
    chk("t2_cnt", 32'(s_cnt), 32'd4);

    // 3: req1 owns a 3-byte packet while req0 waits
    apply_reset();
    push(1, 1'b0, 8'hF0);
    push(1, 1'b0, 8'h0F);
    push(1, 1'b1, 8'h00);
    drive();
    tick();
    push(0, 1'b1, 8'h77);
    drive();
    tick();
    chk("t3_owner_valid0", 32'(s_valid), 32'b0011);
    chk("t3_ready_only1", 32'(s_ready), 32'b0010);
    run_until_idle("t3", 40);
    exp_d = '{8'hF0, 8'h0F, 8'h00, 8'h77};
    exp_s = '{2'd1, 2'd1, 2'd1, 2'd0};
    check_log("t3");
    chk("t3_cnt", 32'(s_cnt), 32'd2);

    // 4: 50-cycle back-pressure stall mid-packet, longer than TIMEOUT
    apply_reset();
    push(0, 1'b0, 8'h01);
    push(0, 1'b0, 8'h02);
    push(0, 1'b1, 8'h03);
    drive();
    tick();
    tick();
    chk("t4_first", 32'(s_wd), 32'h01);
    tx_full = 1'b1;
    st_wr = 1'b0; st_rdy = 1'b0; st_ab = 1'b0; st_busy = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      st_wr   = st_wr | s_wr;
      st_rdy  = st_rdy | (|s_ready);
      st_ab   = st_ab | s_abort;
      st_busy = st_busy & s_busy;
    end
    chk("t4_stall_wr", 32'(st_wr), 32'd0);
    chk("t4_stall_ready", 32'(st_rdy), 32'd0);
    chk("t4_stall_abort", 32'(st_ab), 32'd0);
    chk("t4_stall_busy", 32'(st_busy), 32'd1);
    tx_full = 1'b0;
    run_until_idle("t4", 20);
    exp_d = '{8'h01, 8'h02, 8'h03};
    exp_s = '{2'd0, 2'd0, 2'd0};
    check_log("t4");
    chk("t4_cnt", 32'(s_cnt), 32'd1);

    // 5: req2 goes quiet after one non-last byte, req3 pending
    apply_reset();
    push(2, 1'b0, 8'h5A);
    push(3, 1'b1, 8'h3C);
    drive();
    tick();
    tick();
    chk("t5_grant", 32'(s_grant), 32'b0100);
    chk("t5_byte", 32'(s_wd), 32'h5A);
    first_ab = 0;
    n_ab = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      gr[k] = s_grant;
      cn[k] = s_cnt;
      if (s_abort) begin
        n_ab++;
        if (first_ab == 0) first_ab = k;
      end
    end
    chk("t5_abort_cycle", 32'(first_ab), 32'd11);
    chk("t5_abort_pulses", 32'(n_ab), 32'd1);
    chk("t5_held_grant", 32'(gr[10]), 32'b0100);
    chk("t5_abort_grant", 32'(gr[11]), 32'd0);
    chk("t5_abort_cnt", 32'(cn[11]), 32'd0);
    chk("t5_next_grant", 32'(gr[12]), 32'b1000);
    exp_d = '{8'h5A, 8'h3C};
    exp_s = '{2'd2, 2'd3};
    check_log("t5");
    chk("t5_cnt", 32'(cn[20]), 32'd1);

    // 6: reset while req1 owns after 1 of 3 bytes
    clear_all();
    push(1, 1'b0, 8'hF1);
    push(1, 1'b0, 8'hF2);
    push(1, 1'b1, 8'hF3);
    drive();
    tick();
    tick();
    chk("t6_owner", 32'(s_grant), 32'b0010);
    chk("t6_byte", 32'(s_wd), 32'hF1);
    chk("t6_cnt_before", 32'(s_cnt), 32'd1);
    push(0, 1'b1, 8'h99);
    drive();
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_wr", 32'(wr_uart), 32'd0);
    chk("t6_async_cnt", 32'(pkt_count), 32'd0);
    chk("t6_async_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("t6_in_rst_wr", 32'(s_wr), 32'd0);
    reset = 1'b1;
    log_d.delete();
    log_s.delete();
    tick();
    chk("t6_idle_grant", 32'(s_grant), 32'd0);
    tick();
    chk("t6_req0_wins", 32'(s_grant), 32'b0001);
    chk("t6_req0_byte", 32'(s_wd), 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
